// File: rtl/prog_pkg.sv
// Shared types for the UART multi-memory programmer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEL,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } prog_state_e;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_FRAME  = 3'd1,
    ERR_HDR    = 3'd2,
    ERR_CSUM   = 3'd3,
    ERR_ABORT  = 3'd4
  } err_e;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_uart_rx.sv
// 8N1 UART byte receiver with mid-bit sampling and start-bit glitch rejection.
// Latency: valid_o/frame_err_o pulse one cycle after the stop-bit sample.
// Backpressure: none; each byte is presented for exactly one cycle.
module prog_uart_rx #(
  parameter int CLKS_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CLKS_W-1:0] clks_per_bit_i,
  input  logic              rx_i,
  output logic [7:0]        byte_o,
  output logic              valid_o,
  output logic              frame_err_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e         state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CLKS_W-1:0] cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              valid_q, valid_d, ferr_q, ferr_d;
  logic [CLKS_W-1:0] cpb, half;

  // Very short bit periods leave no room for a meaningful mid-bit sample.
  assign cpb  = (clks_per_bit_i < CLKS_W'(4)) ? CLKS_W'(4) : clks_per_bit_i;
  assign half = cpb >> 1;

  assign byte_o      = shift_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

  // Register stage: line synchroniser, bit timer, shift register, output pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit-timing state machine; sync2_q is the line as seen by the receiver.
  always_comb begin
    state_d = state_q;
    sync1_d = rx_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == half - CLKS_W'(1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CLKS_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == cpb - CLKS_W'(1)) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = RX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CLKS_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == cpb - CLKS_W'(1)) begin
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + CLKS_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/multi_mem_programmer.sv
// UART boot loader: parses a framed image and writes 32-bit words into one of several memories.
// Latency: write strobe one cycle after the 4th byte of a word; status one cycle after the checksum byte.
// Backpressure: none; the memory port must accept a write on every we_o pulse.
module multi_mem_programmer import prog_pkg::*; #(
  parameter int NUM_TARGETS = 2,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int CLKS_W      = 16,
  parameter int MAX_WORDS   = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   prog_i,
  input  logic [CLKS_W-1:0]      clks_per_bit_i,
  input  logic                   rx_i,
  output logic [NUM_TARGETS-1:0] we_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [DATA_W-1:0]      wdata_o,
  output logic [3:0]             wmask_o,
  output logic                   core_rst_no,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [2:0]             err_o
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr;

  prog_uart_rx #(.CLKS_W(CLKS_W)) u_rx (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rx_i           (rx_i),
    .byte_o         (rx_byte),
    .valid_o        (rx_vld),
    .frame_err_o    (rx_ferr)
  );

  prog_state_e           state_q, state_d;
  logic [2:0]            sel_q, sel_d;
  logic [15:0]           len_q, len_d, words_q, words_d, len_full;
  logic [1:0]            bidx_q, bidx_d;
  logic [7:0]            csum_q, csum_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [NUM_TARGETS-1:0] we_q, we_d;
  logic                  done_q, done_d;
  err_e                  err_q, err_d;

  assign len_full    = {rx_byte, len_q[7:0]};
  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign wmask_o     = (|we_q) ? 4'hF : 4'h0;
  assign core_rst_no = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign done_o      = done_q;
  assign err_o       = err_q;

  // State register; reset drops any partially assembled word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      bidx_q  <= '0;
      csum_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      words_q <= words_d;
      bidx_q  <= bidx_d;
      csum_q  <= csum_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Frame parser; prog_i falling takes priority over a byte arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    words_d = words_q;
    bidx_d  = bidx_q;
    csum_d  = csum_q;
    wdata_d = wdata_q;
    addr_d  = (|we_q) ? addr_q + ADDR_W'(1) : addr_q;
    we_d    = '0;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (prog_i) begin
          state_d = ST_SYNC;
          done_d  = 1'b0;
          err_d   = ERR_NONE;
          addr_d  = '0;
          words_d = '0;
          bidx_d  = '0;
          csum_d  = '0;
        end
      end
      ST_SYNC, ST_SEL, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: begin
        if (!prog_i) begin
          state_d = ST_IDLE;
          err_d   = ERR_ABORT;
        end else if (rx_ferr) begin
          state_d = ST_ERR;
          err_d   = ERR_FRAME;
        end else if (rx_vld) begin
          case (state_q)
            ST_SYNC: if (rx_byte == SYNC_BYTE) state_d = ST_SEL;
            ST_SEL: begin
              if (rx_byte >= 8'(NUM_TARGETS)) begin
                state_d = ST_ERR;
                err_d   = ERR_HDR;
              end else begin
                sel_d   = rx_byte[2:0];
                state_d = ST_LEN0;
              end
            end
            ST_LEN0: begin
              len_d[7:0] = rx_byte;
              state_d    = ST_LEN1;
            end
            ST_LEN1: begin
              len_d = len_full;
              if (len_full > 16'(MAX_WORDS)) begin
                state_d = ST_ERR;
                err_d   = ERR_HDR;
              end else if (len_full == 16'd0) begin
                state_d = ST_CSUM;
              end else begin
                state_d = ST_DATA;
              end
            end
            ST_DATA: begin
              wdata_d[8*bidx_q +: 8] = rx_byte;
              csum_d = csum_q ^ rx_byte;
              bidx_d = bidx_q + 2'd1;
              if (bidx_q == 2'(BYTES_PER_WORD - 1)) begin
                for (int i = 0; i < NUM_TARGETS; i++) we_d[i] = (sel_q == 3'(i));
                words_d = words_q + 16'd1;
                if (words_q + 16'd1 == len_q) state_d = ST_CSUM;
              end
            end
            ST_CSUM: begin
              if (rx_byte == csum_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_ERR;
                err_d   = ERR_CSUM;
              end
            end
            default: ;
          endcase
        end
      end
      ST_DONE, ST_ERR: if (!prog_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
